// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with input synchroniser, valid strobe and stop-bit error flag
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_clock,
    input  logic       i_resetN,
    input  logic       i_rxSerial,
    output logic [7:0] o_rxData,
    output logic       o_rxValid,
    output logic       o_rxBusy,
    output logic       o_frameError
);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ferr_q, ferr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_rx;

    assign s_rx         = sync_q[SYNC_STAGES-1];
    assign o_rxData     = data_q;
    assign o_rxValid    = valid_q;
    assign o_rxBusy     = busy_q;
    assign o_frameError = ferr_q;

    // Shift the raw line through the synchroniser chain, oldest sample at the top
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_rxSerial};
    end

    // Frame FSM: start validation at mid-bit, then one sample per bit period
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (!s_rx) begin
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = START;
            end
            START: if (cnt_q == CW'(HALF)) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = s_rx ? IDLE : DATA;
                busy_d  = !s_rx;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d          = '0;
                shift_d[idx_q] = s_rx;
                idx_d          = idx_q + 1'b1;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                cnt_d   = '0;
                data_d  = s_rx ? shift_q : data_q;
                valid_d = s_rx;
                ferr_d  = !s_rx;
                busy_d  = !s_rx;
                state_d = s_rx ? IDLE : WAIT_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_IDLE: if (s_rx) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchroniser presets to idle-high
    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            sync_q  <= sync_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed checks of uart_rx at 4 and 8 clocks per bit
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx4 = 1'b1, rx8 = 1'b1;
    logic [7:0] data4, data8;
    logic       v4, v8, b4, b8, fe4, fe8;
    int         checks = 0, errors = 0;
    int         vc4 = 0, vc8 = 0, fc4 = 0, fc8 = 0, bf4 = 0, br8 = 0, both = 0;
    logic       bprev4 = 1'b0, bprev8 = 1'b0;
    logic [7:0] got4 [8];
    int         lat, s_v, s_f, s_b;

    uart_rx #(.CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut4 (
        .i_clock(clk), .i_resetN(rst_n), .i_rxSerial(rx4),
        .o_rxData(data4), .o_rxValid(v4), .o_rxBusy(b4), .o_frameError(fe4)
    );
    uart_rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
        .i_clock(clk), .i_resetN(rst_n), .i_rxSerial(rx8),
        .o_rxData(data8), .o_rxValid(v8), .o_rxBusy(b8), .o_frameError(fe8)
    );

    always #5 clk = ~clk;

    // Pulse and edge counters sampled on the falling edge
    always @(negedge clk) begin
        bprev4 <= b4;
        bprev8 <= b8;
        if (v4) begin
            got4[vc4 % 8] <= data4;
            vc4 <= vc4 + 1;
        end
        if (v8) vc8 <= vc8 + 1;
        if (fe4) fc4 <= fc4 + 1;
        if (fe8) fc8 <= fc8 + 1;
        if (bprev4 && !b4) bf4 <= bf4 + 1;
        if (!bprev8 && b8) br8 <= br8 + 1;
        if ((v4 && fe4) || (v8 && fe8)) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx8 = v;
        else rx4 = v;
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop, input int cpb);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            set_line(sel, f[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(sel, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data4", data4, 8'h00);
        chk("rst_outs4", {v4, b4, fe4}, 3'b000);
        chk("rst_outs8", {v8, b8, fe8}, 3'b000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // back-to-back frames with one idle bit
        s_v = vc4; s_f = fc4; s_b = bf4;
        send_byte(1'b0, 8'hCC, 1'b1, 4);
        repeat (4) @(negedge clk);
        send_byte(1'b0, 8'hDD, 1'b1, 4);
        repeat (20) @(negedge clk);
        chk("t1_vcount", vc4 - s_v, 2);
        chk("t1_byte0", got4[s_v % 8], 8'hCC);
        chk("t1_byte1", got4[(s_v + 1) % 8], 8'hDD);
        chk("t1_ferr", fc4 - s_f, 0);
        chk("t1_busyfall", bf4 - s_b, 2);

        // latency from first edge seeing the start bit
        lat = -1;
        fork
            send_byte(1'b0, 8'h5A, 1'b1, 4);
            begin
                for (int n = 1; n <= 200; n++) begin
                    @(negedge clk);
                    if (v4) begin
                        lat = n - 1;
                        break;
                    end
                end
            end
        join
        chk("t6_lat_in_range", (lat >= 39 && lat <= 41), 1);
        chk("t6_data", data4, 8'h5A);
        repeat (10) @(negedge clk);

        // short glitch is rejected
        s_v = vc8; s_f = fc8; s_b = br8;
        rx8 = 1'b0;
        repeat (2) @(negedge clk);
        rx8 = 1'b1;
        repeat (2) @(negedge clk);
        chk("t2_busy_high", b8, 1);
        repeat (5) @(negedge clk);
        chk("t2_busy_low", b8, 0);
        repeat (20) @(negedge clk);
        chk("t2_busyrise", br8 - s_b, 1);
        chk("t2_noflags", {vc8 - s_v, fc8 - s_f}, 0);

        // bad stop bit, then a good frame
        s_v = vc8; s_f = fc8;
        send_byte(1'b1, 8'hA5, 1'b0, 8);
        repeat (24) @(negedge clk);
        chk("t3_ferr", fc8 - s_f, 1);
        chk("t3_novalid", vc8 - s_v, 0);
        chk("t3_data_kept", data8, 8'h00);
        send_byte(1'b1, 8'h3C, 1'b1, 8);
        repeat (10) @(negedge clk);
        chk("t3_valid", vc8 - s_v, 1);
        chk("t3_data", data8, 8'h3C);

        // break condition
        s_v = vc8; s_f = fc8;
        rx8 = 1'b0;
        repeat (160) @(negedge clk);
        chk("t4_busy_in_break", b8, 1);
        chk("t4_one_ferr", fc8 - s_f, 1);
        rx8 = 1'b1;
        repeat (16) @(negedge clk);
        chk("t4_busy_released", b8, 0);
        send_byte(1'b1, 8'h55, 1'b1, 8);
        repeat (10) @(negedge clk);
        chk("t4_valid", vc8 - s_v, 1);
        chk("t4_data", data8, 8'h55);
        chk("t4_ferr_total", fc8 - s_f, 1);

        // reset during data bit 4
        s_v = vc8; s_f = fc8;
        fork
            send_byte(1'b1, 8'hF0, 1'b1, 8);
            begin
                repeat (44) @(negedge clk);
                chk("t5_busy_pre", b8, 1);
                rst_n = 1'b0;
                #1;
                chk("t5_rst_data", data8, 8'h00);
                chk("t5_rst_busy", b8, 0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("t5_nopulse", {vc8 - s_v, fc8 - s_f}, 0);
        send_byte(1'b1, 8'h0F, 1'b1, 8);
        repeat (10) @(negedge clk);
        chk("t5_valid", vc8 - s_v, 1);
        chk("t5_data", data8, 8'h0F);
        chk("never_both", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
